// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock/reset sequencer.
// Holds the FSM state encoding and the counter-width helper.
package pll_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    // Returns the ceil-log2 of the largest of three cycle counts.
    function automatic int unsigned clog2_max(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, releases sys_rst,
// retries on lock timeout and latches a sticky failure after too many timeouts.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter  int unsigned RST_PULSE_CYCLES = 16,
    parameter  int unsigned LOCK_TIMEOUT     = 65536,
    parameter  int unsigned STABLE_CYCLES    = 1024,
    parameter  int unsigned MAX_RETRIES      = 3,
    localparam int unsigned RW               = $clog2(MAX_RETRIES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          locked_async,
    output logic          pll_rst,
    output logic          sys_rst,
    output logic          ready,
    output logic          fail,
    output logic [RW-1:0] retry_cnt
);

    localparam int unsigned CW = clog2_max(RST_PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [RW-1:0]   retry_d;
    logic            locked_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked_async),
        .q     (locked_s)
    );

    // State, shared counter and decoded output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst   <= (state_d == S_PLLRST) || (state_d == S_FAIL);
            sys_rst   <= (state_d != S_RUN);
            ready     <= (state_d == S_RUN);
            fail      <= (state_d == S_FAIL);
            retry_cnt <= retry_d;
        end
    end

    // Next state, counter and retry count; lock loss and lock arrival take priority over timeouts.
    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        cnt_d   = '0;

        case (state_q)
            S_PLLRST: begin
                if (cnt_q == CW'(RST_PULSE_CYCLES - 1)) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_cnt + RW'(1);
                    state_d = (retry_d == RW'(MAX_RETRIES)) ? S_FAIL : S_PLLRST;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) state_d = S_PLLRST;
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_PLLRST;
            end
        endcase

        if (state_d == S_RUN) retry_d = '0;

        // The counter only runs in the timed states and restarts on every transition.
        if ((state_d == state_q) && (state_q != S_RUN) && (state_q != S_FAIL)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed scenarios plus random lock waveforms,
// checked cycle by cycle against a phase/timestamp reference model.
module tb_pll_lock_reset_seq;

    localparam int unsigned RP    = 4;
    localparam int unsigned LT    = 20;
    localparam int unsigned SC    = 8;
    localparam int unsigned MR    = 3;
    localparam int unsigned TB_RW = $clog2(MR + 1);
    localparam int unsigned VW    = 4 + TB_RW;

    localparam int P_HOLD = 7;
    localparam int P_SEEK = 11;
    localparam int P_QUAL = 13;
    localparam int P_LIVE = 17;
    localparam int P_DEAD = 19;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              locked_async = 1'b0;
    logic              pll_rst;
    logic              sys_rst;
    logic              ready;
    logic              fail;
    logic [TB_RW-1:0]  retry_cnt;
    logic [VW-1:0]     dut_vec;

    int n_cmp = 0;
    int n_err = 0;

    pll_lock_reset_seq #(
        .RST_PULSE_CYCLES (RP),
        .LOCK_TIMEOUT     (LT),
        .STABLE_CYCLES    (SC),
        .MAX_RETRIES      (MR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked_async (locked_async),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt)
    );

    always #5 clk = ~clk;

    assign dut_vec = {pll_rst, sys_rst, ready, fail, retry_cnt};

    // Reference model: phase, the edge at which it was entered, and missed-lock count.
    int         m_phase = P_HOLD;
    int         m_entry = 0;
    int         m_cyc   = 0;
    int         m_miss  = 0;
    logic [1:0] m_pipe  = 2'b00;

    always @(posedge clk or negedge rst_n) begin : model
        int   age;
        int   nxt;
        logic seen;
        if (!rst_n) begin
            m_phase = P_HOLD;
            m_entry = 0;
            m_cyc   = 0;
            m_miss  = 0;
            m_pipe  = 2'b00;
        end else begin
            seen = m_pipe[1];
            age  = m_cyc - m_entry;
            nxt  = m_phase;
            if (m_phase == P_HOLD) begin
                if (age == RP - 1) nxt = P_SEEK;
            end else if (m_phase == P_SEEK) begin
                if (seen) nxt = P_QUAL;
                else if (age == LT - 1) begin
                    m_miss = m_miss + 1;
                    nxt = (m_miss == MR) ? P_DEAD : P_HOLD;
                end
            end else if (m_phase == P_QUAL) begin
                if (!seen) nxt = P_SEEK;
                else if (age == SC - 1) begin
                    nxt = P_LIVE;
                    m_miss = 0;
                end
            end else if (m_phase == P_LIVE) begin
                if (!seen) nxt = P_HOLD;
            end
            m_pipe = {m_pipe[0], locked_async};
            m_cyc  = m_cyc + 1;
            if (nxt != m_phase) begin
                m_phase = nxt;
                m_entry = m_cyc;
            end
        end
    end

    function automatic logic [VW-1:0] m_out(input int ph, input int miss);
        return {(ph == P_HOLD) || (ph == P_DEAD), ph != P_LIVE, ph == P_LIVE,
                ph == P_DEAD, TB_RW'(miss)};
    endfunction

    // One clock: lk is applied just after this edge and sampled at the next one.
    task automatic step(input logic lk);
        @(posedge clk);
        #2 locked_async = lk;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        locked_async = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        locked_async = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== 6'b110000) begin
                n_err++;
                $display("FAIL reset_values got=%b want=%b", dut_vec, 6'b110000);
            end
        end
        locked_async = 1'b0;
    endtask

    task automatic test_nominal();
        int t_pll;
        int t_sys;
        do_reset();
        t_pll = -1;
        t_sys = -1;
        for (int i = 1; i <= 30; i++) begin
            step(i >= 5);
            n_cmp++;
            if (dut_vec !== m_out(m_phase, m_miss)) begin
                n_err++;
                $display("FAIL nominal step=%0d got=%b want=%b", i, dut_vec, m_out(m_phase, m_miss));
            end
            if (t_pll < 0 && pll_rst == 1'b0) t_pll = i;
            if (t_sys < 0 && sys_rst == 1'b0) t_sys = i;
        end
        n_cmp++;
        if (t_pll != 4) begin
            n_err++;
            $display("FAIL nominal_pll_rst_fall got=%0d want=4", t_pll);
        end
        n_cmp++;
        if (t_sys != 16) begin
            n_err++;
            $display("FAIL nominal_sys_rst_fall got=%0d want=16", t_sys);
        end
    endtask

    task automatic test_retry_fail();
        int rises;
        int t_fail;
        logic prev;
        do_reset();
        rises  = 0;
        t_fail = -1;
        prev   = 1'b1;
        for (int i = 1; i <= 90; i++) begin
            step(1'b0);
            n_cmp++;
            if (dut_vec !== m_out(m_phase, m_miss)) begin
                n_err++;
                $display("FAIL retry step=%0d got=%b want=%b", i, dut_vec, m_out(m_phase, m_miss));
            end
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
            if (t_fail < 0 && fail) t_fail = i;
        end
        n_cmp++;
        if (t_fail != 72 || rises != 3 || retry_cnt !== 2'd3 || pll_rst !== 1'b1) begin
            n_err++;
            $display("FAIL retry_summary got fail_at=%0d rises=%0d retry=%0d pll_rst=%b want 72/3/3/1",
                     t_fail, rises, retry_cnt, pll_rst);
        end
    endtask

    task automatic test_stable_glitch();
        int   drop_left;
        bit   dropped;
        int   t_ready;
        int   pll_hi;
        do_reset();
        drop_left = 0;
        dropped   = 0;
        t_ready   = -1;
        pll_hi    = 0;
        for (int i = 1; i <= 40; i++) begin
            step(drop_left == 0);
            if (drop_left > 0) drop_left--;
            n_cmp++;
            if (dut_vec !== m_out(m_phase, m_miss)) begin
                n_err++;
                $display("FAIL glitch step=%0d got=%b want=%b", i, dut_vec, m_out(m_phase, m_miss));
            end
            if (!dropped && m_phase == P_QUAL && (m_cyc - m_entry) == 4) begin
                drop_left = 3;
                dropped   = 1;
            end
            if (i > RP && pll_rst) pll_hi++;
            if (t_ready < 0 && ready) t_ready = i;
        end
        n_cmp++;
        if (t_ready != 24 || pll_hi != 0) begin
            n_err++;
            $display("FAIL glitch_summary got ready_at=%0d pll_hi=%0d want 24/0", t_ready, pll_hi);
        end
    endtask

    task automatic test_run_loss();
        int t_ready;
        int lat;
        int pll_hi;
        int retry_bad;
        do_reset();
        t_ready = -1;
        for (int i = 1; i <= 40 && t_ready < 0; i++) begin
            step(1'b1);
            if (ready) t_ready = i;
        end
        n_cmp++;
        if (t_ready != 13) begin
            n_err++;
            $display("FAIL run_entry got=%0d want=13", t_ready);
        end
        lat = -1;
        pll_hi = 0;
        retry_bad = 0;
        for (int i = 1; i <= 30; i++) begin
            step(i > 2);
            n_cmp++;
            if (dut_vec !== m_out(m_phase, m_miss)) begin
                n_err++;
                $display("FAIL run_loss step=%0d got=%b want=%b", i, dut_vec, m_out(m_phase, m_miss));
            end
            if (lat < 0 && sys_rst && !ready) lat = i;
            if (pll_rst) pll_hi++;
            if (retry_cnt !== '0) retry_bad++;
        end
        n_cmp++;
        if (lat != 4 || pll_hi != 4 || retry_bad != 0) begin
            n_err++;
            $display("FAIL run_loss_summary got lat=%0d pll_hi=%0d retry_bad=%0d want 4/4/0",
                     lat, pll_hi, retry_bad);
        end
    endtask

    task automatic test_timeout_race(input int raise_step, input logic want_pll,
                                     input logic [TB_RW-1:0] want_retry);
        do_reset();
        for (int i = 1; i <= 34; i++) begin
            step(i >= raise_step);
            n_cmp++;
            if (dut_vec !== m_out(m_phase, m_miss)) begin
                n_err++;
                $display("FAIL race step=%0d got=%b want=%b", i, dut_vec, m_out(m_phase, m_miss));
            end
            if (i == 24) begin
                n_cmp++;
                if (pll_rst !== want_pll || retry_cnt !== want_retry || sys_rst !== 1'b1) begin
                    n_err++;
                    $display("FAIL race_edge raise=%0d got pll_rst=%b retry=%0d want %b/%0d",
                             raise_step, pll_rst, retry_cnt, want_pll, want_retry);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int t_ready;
        do_reset();
        repeat (20) step(1'b1);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre_run got ready=%b want 1", ready);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 6'b110000) begin
            n_err++;
            $display("FAIL async_in_run got=%b want=%b", dut_vec, 6'b110000);
        end
        locked_async = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) step(1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 6'b110000) begin
            n_err++;
            $display("FAIL async_in_fail got=%b want=%b", dut_vec, 6'b110000);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t_ready = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1'b1);
            n_cmp++;
            if (dut_vec !== m_out(m_phase, m_miss)) begin
                n_err++;
                $display("FAIL async_rerun step=%0d got=%b want=%b", i, dut_vec, m_out(m_phase, m_miss));
            end
            if (t_ready < 0 && ready) t_ready = i;
        end
        n_cmp++;
        if (t_ready != 13) begin
            n_err++;
            $display("FAIL async_rerun_ready got=%0d want=13", t_ready);
        end
    endtask

    task automatic test_random();
        logic lk;
        for (int run = 0; run < 4; run++) begin
            do_reset();
            lk = 1'b0;
            for (int i = 1; i <= 500; i++) begin
                if ($urandom_range(0, 11) == 0) lk = ~lk;
                step(lk);
                n_cmp++;
                if (dut_vec !== m_out(m_phase, m_miss)) begin
                    n_err++;
                    $display("FAIL random run=%0d step=%0d got=%b want=%b",
                             run, i, dut_vec, m_out(m_phase, m_miss));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_retry_fail();
        test_stable_glitch();
        test_run_loss();
        test_timeout_race(21, 1'b0, 2'd0);
        test_timeout_race(22, 1'b1, 2'd1);
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
